// File: rtl/lab6_prio_arb_if.sv
// Request/selection bundle between request sources and the priority arbiter.
// The grant vector exists only when LAB6_PRIO_ONEHOT_EN is defined.
interface lab6_prio_arb_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  // valid/ready: y is transferred on every rising edge where valid && out_ready;
  // while valid && !out_ready the arbiter holds y/valid/grant stable.
  logic [N-1:0] req;
  logic [1:0]   mode;
  logic         out_ready;
  logic [W-1:0] y;
  logic         valid;
`ifdef LAB6_PRIO_ONEHOT_EN
  logic [N-1:0] grant;

  modport master (output req, mode, out_ready, input y, valid, grant);
  modport slave  (input req, mode, out_ready, output y, valid, grant);
`else
  modport master (output req, mode, out_ready, input y, valid);
  modport slave  (input req, mode, out_ready, output y, valid);
`endif
endinterface

// File: rtl/lab6_prio_arb.sv
// Registered priority encoder / arbiter: fixed-high, fixed-low or round-robin.
// Optional one-hot grant output enabled by defining LAB6_PRIO_ONEHOT_EN.
module lab6_prio_arb #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  lab6_prio_arb_if.slave  bus
);
  logic [W-1:0] ptr;
  logic [W-1:0] next_ptr;
  logic [W-1:0] rr_base;
  logic [W-1:0] sel_hi;
  logic [W-1:0] sel_lo;
  logic [W-1:0] sel_rr;
  logic [W-1:0] sel;
  logic         handshake;
  logic         free;

  assign handshake = bus.valid && bus.out_ready;
  assign free      = !bus.valid || bus.out_ready;
  assign next_ptr  = (bus.y == W'(N - 1)) ? '0 : bus.y + W'(1);

  // On an accepting edge the round-robin scan starts from the pointer value
  // being written that same edge, so back-to-back grants rotate every cycle.
  assign rr_base = handshake ? next_ptr : ptr;

  always_comb begin
    int idx;
    idx    = 0;
    sel_hi = '0;
    sel_lo = '0;
    sel_rr = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) sel_hi = W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) sel_lo = W'(i);
    end
    // Scan from the far end back to rr_base so the nearest set index wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_base) + k;
      if (idx >= N) idx = idx - N;
      if (bus.req[idx]) sel_rr = W'(idx);
    end
  end

  always_comb begin
    case (bus.mode)
      2'b01:   sel = sel_lo;
      2'b10:   sel = sel_rr;
      default: sel = sel_hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      bus.y     <= '0;
      bus.valid <= 1'b0;
`ifdef LAB6_PRIO_ONEHOT_EN
      bus.grant <= '0;
`endif
    end else begin
      if (handshake) ptr <= next_ptr;
      if (free) begin
        if (|bus.req) begin
          bus.y     <= sel;
          bus.valid <= 1'b1;
`ifdef LAB6_PRIO_ONEHOT_EN
          bus.grant <= N'(1) << sel;
`endif
        end else begin
          bus.valid <= 1'b0;
`ifdef LAB6_PRIO_ONEHOT_EN
          bus.grant <= '0;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_lab6_prio_arb.sv
// Directed and random checks of lab6_prio_arb (N=8) against hand values and a model.
// Grant checks are compiled in when LAB6_PRIO_ONEHOT_EN is defined.
module tb_lab6_prio_arb;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int m_y;
  int m_valid;
  int m_ptr;

  lab6_prio_arb_if #(.N(N)) intf ();

  lab6_prio_arb #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_sel(input logic [7:0] r, input logic [1:0] md, input int base);
    int idx;
    if (md == 2'b01) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else if (md == 2'b10) begin
      for (int k = 0; k < N; k++) begin
        idx = (base + k) % N;
        if (r[idx]) return idx;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_y = 0;
    m_valid = 0;
    m_ptr = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_y"}, 32'(intf.y), 32'(m_y));
    chk({tag, "_valid"}, 32'(intf.valid), 32'(m_valid));
`ifdef LAB6_PRIO_ONEHOT_EN
    chk({tag, "_grant"}, 32'(intf.grant), m_valid != 0 ? (32'd1 << m_y) : 32'd0);
`endif
  endtask

  // Advance the model for the coming edge, clock once, then compare.
  task automatic cycle(input string tag);
    int s;
    int base;
    bit hs;
    bit fr;
    hs   = (m_valid != 0) && intf.out_ready;
    fr   = (m_valid == 0) || intf.out_ready;
    base = hs ? (m_y + 1) % N : m_ptr;
    s    = m_sel(intf.req, intf.mode, base);
    if (hs) m_ptr = (m_y + 1) % N;
    if (fr) begin
      if (s >= 0) begin
        m_y = s;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    intf.req = '0;
    intf.mode = 2'b00;
    intf.out_ready = 1'b1;
    model_reset();
    #2;
    chk("reset_y", 32'(intf.y), 32'd0);
    chk("reset_valid", 32'(intf.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset mid-operation
    intf.req = 8'b0010_0000;
    cycle("t1_load");
    chk("t1_y5", 32'(intf.y), 32'd5);
    chk("t1_v1", 32'(intf.valid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_async_y", 32'(intf.y), 32'd0);
    chk("t1_async_valid", 32'(intf.valid), 32'd0);
    intf.req = '0;
    #2;
    rst_n = 1'b1;
    cycle("t1_idle");
    chk("t1_idle_valid", 32'(intf.valid), 32'd0);

    // 2: fixed-high
    intf.mode = 2'b00;
    intf.req = 8'b0100_1010;
    cycle("t2_load");
    chk("t2_y6", 32'(intf.y), 32'd6);
    chk("t2_v1", 32'(intf.valid), 32'd1);
`ifdef LAB6_PRIO_ONEHOT_EN
    chk("t6_grant", 32'(intf.grant), 32'h40);
`endif
    intf.req = '0;
    cycle("t2_drop");
    chk("t2_v0", 32'(intf.valid), 32'd0);
    chk("t2_yhold", 32'(intf.y), 32'd6);
`ifdef LAB6_PRIO_ONEHOT_EN
    chk("t6_grant0", 32'(intf.grant), 32'h0);
`endif

    // 3: fixed-low
    intf.mode = 2'b01;
    intf.req = 8'b0100_1010;
    cycle("t3_a");
    chk("t3_y1", 32'(intf.y), 32'd1);
    intf.req = 8'b1000_0000;
    cycle("t3_b");
    chk("t3_y7", 32'(intf.y), 32'd7);

    // 4: round-robin from ptr=0 with wrap
    intf.req = '0;
    @(negedge clk);
    do_reset();
    intf.mode = 2'b10;
    intf.req = 8'b1000_0101;
    cycle("t4_0");
    chk("t4_seq0", 32'(intf.y), 32'd0);
    cycle("t4_1");
    chk("t4_seq2", 32'(intf.y), 32'd2);
    cycle("t4_2");
    chk("t4_seq7", 32'(intf.y), 32'd7);
    cycle("t4_3");
    chk("t4_seq0b", 32'(intf.y), 32'd0);
    cycle("t4_4");
    chk("t4_seq2b", 32'(intf.y), 32'd2);

    // 5: stall holds y despite req and mode changes
    intf.mode = 2'b00;
    intf.req = 8'b0011_0000;
    cycle("t5_load");
    chk("t5_y5", 32'(intf.y), 32'd5);
    intf.out_ready = 1'b0;
    intf.req = 8'b1000_0000;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) intf.mode = 2'b01;
      cycle("t5_stall");
      chk("t5_hold_y", 32'(intf.y), 32'd5);
      chk("t5_hold_v", 32'(intf.valid), 32'd1);
    end
    intf.out_ready = 1'b1;
    cycle("t5_release");
    chk("t5_y7", 32'(intf.y), 32'd7);

    // Single request: every mode picks it, whatever ptr is
    for (int md = 0; md < 4; md++) begin
      intf.mode = 2'(md);
      intf.req = 8'b0000_1000;
      cycle("single");
      chk("single_y3", 32'(intf.y), 32'd3);
    end

    // Random req/ready/mode traffic against the model
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: intf.req = '0;
        1: intf.req = 8'd1 << $urandom_range(0, 7);
        default: intf.req = 8'($urandom_range(0, 255));
      endcase
      intf.mode = 2'($urandom_range(0, 3));
      intf.out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
